// File: rtl/vector_requantize.sv
// Narrows a vector of signed Q32.32 elements to signed Q16.16, one element per
// enabled clock, with round-half-up at bit 15 and saturation to 32 bits.
module vector_requantize #(
  parameter int LENGTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [64*LENGTH-1:0]  P,
  output logic [32*LENGTH-1:0]  Z,
  output logic [LENGTH-1:0]     sat,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int IDXW = $clog2(LENGTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [IDXW-1:0]       r_idx;
  logic [64*LENGTH-1:0]  r_p;
  logic [32*LENGTH-1:0]  r_z;
  logic [LENGTH-1:0]     r_sat;
  logic                  r_out_valid;
  logic                  w_in_ready;
  logic                  w_accept;
  logic                  w_last;
  logic [63:0]           w_elem;
  logic [32:0]           w_conv;

  // Returns {saturated, q16.16}; the 65-bit sum cannot overflow for any 64-bit input.
  function automatic logic [32:0] requant(input logic [63:0] e);
    logic signed [64:0] r;
    logic signed [64:0] t;
    r = $signed({e[63], e}) + 65'sh0_0000_0000_0000_8000;
    t = r >>> 16;
    if (t > 65'sh0_0000_0000_7FFF_FFFF) begin
      requant = {1'b1, 32'h7FFF_FFFF};
    end else if (t < 65'sh1_FFFF_FFFF_8000_0000) begin
      requant = {1'b1, 32'h8000_0000};
    end else begin
      requant = {1'b0, t[31:0]};
    end
  endfunction

  assign w_in_ready = rst_n & ce & (r_state == S_IDLE);
  assign w_accept   = ce & in_valid & w_in_ready;
  assign w_last     = (r_idx == IDXW'(LENGTH - 1));

  // Selects the captured element addressed by the running index.
  always_comb begin
    w_elem = 64'h0;
    for (int i = 0; i < LENGTH; i++) begin
      w_elem = (r_idx == IDXW'(i)) ? r_p[64*i +: 64] : w_elem;
    end
    w_conv = requant(w_elem);
  end

  // Next-state logic for the accept / convert / hold sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, capture and in-place result registers; everything freezes while ce is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_p         <= '0;
      r_z         <= '0;
      r_sat       <= '0;
      r_out_valid <= 1'b0;
    end else if (ce) begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_p   <= P;
            r_idx <= '0;
          end
        end
        S_RUN: begin
          for (int i = 0; i < LENGTH; i++) begin
            if (r_idx == IDXW'(i)) begin
              r_z[32*i +: 32] <= w_conv[31:0];
              r_sat[i]        <= w_conv[32];
            end
          end
          r_idx <= r_idx + IDXW'(1);
          if (w_last) begin
            r_out_valid <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
          end
        end
        default: r_out_valid <= 1'b0;
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign Z         = r_z;
  assign sat       = r_sat;
  assign out_valid = r_out_valid;

endmodule

// File: doc/vector_requantize.md
# vector_requantize

Narrows a vector of signed Q32.32 elements, as produced by `vector_scale_add` on its P port, back to signed Q16.16 with round-half-up and saturation. One element is processed per enabled clock. The result vector is re-packed so it can be fed straight back as the X or Y-low operand of the next scale/add stage. It sits on the return path of the filter datapath, between the 64-bit-per-element MAC outputs and the 32-bit-per-element state registers.

## Interface
- `LENGTH`, 5, number of vector elements (≥1).
- `clk` in 1, rising-edge clock.
- `rst_n` in 1, asynchronous active-low reset.
- `ce` in 1, clock enable. Low freezes all state, counters and outputs.
- `in_valid` in 1, P vector offered.
- `in_ready` out 1, block can accept. Combinational: `rst_n & ce & (state==IDLE)`.
- `P` in 64*LENGTH, input vector; element i = `P[64*i+63 : 64*i]`, signed Q32.32.
- `Z` out 32*LENGTH, result vector; element i = `Z[32*i+31 : 32*i]`, signed Q16.16.
- `sat` out LENGTH, bit i set if element i saturated.
- `out_valid` out 1, Z/sat complete and stable.
- `out_ready` in 1, consumer takes Z.

## Operation
- States: IDLE, RUN, DONE. Element index counter `idx` is ceil(log2(LENGTH+1)) bits wide.
- IDLE: at an edge with `ce & in_valid & in_ready`:
  - capture P into an internal 64*LENGTH register;
  - clear `idx` to 0;
  - go to RUN.
  - Z and sat keep their previous values until they are overwritten.
- RUN, each enabled edge:
  - convert element `idx`, write it to Z slot `idx` and sat bit `idx`, then increment `idx`;
  - on the edge that writes element LENGTH-1, go to DONE and set `out_valid`.
- DONE: `out_valid`=1; Z and sat are held. At an enabled edge with `out_ready`, clear `out_valid` and go to IDLE.
- No overlap between vectors: a new vector is accepted only from IDLE, so the earliest next accept is the edge after the DONE→IDLE edge.
- Conversion of element e (64-bit signed):
  - r = sign-extend(e) to 65 bits, then + 0x8000;
  - t = r >>> 16 (arithmetic shift);
  - if t > 0x7FFFFFFF: Z = 0x7FFFFFFF, sat=1;
  - else if t < −0x80000000: Z = 0x80000000, sat=1;
  - else Z = t[31:0], sat=0.
  - Effect: round half toward +∞ at bit 15, then saturate to 32 bits.
- `in_valid` held while IDLE but `ce` low: nothing is accepted. `out_ready` held while not in DONE: ignored.
- `rst_n` low at any time, including mid-RUN:
  - state IDLE, `idx`=0, captured P=0;
  - Z=0, sat=0, `out_valid`=0, `in_ready`=0.
  - A partially converted vector is discarded.

## Timing
- Reset values: Z=0, sat=0, `out_valid`=0, `in_ready`=0 while `rst_n` low.
- After `rst_n` rises, `in_ready` = `ce` immediately, since the state is IDLE.
- Latency:
  - accept edge = edge 0;
  - element i is written at edge i+1;
  - `out_valid` rises after edge LENGTH;
  - `in_ready` returns the cycle after the `out_ready` handshake edge.
- Throughput: one vector per LENGTH+2 enabled cycles when `out_ready` is held high.
- `ce` low for k cycles stretches every figure above by exactly k. Edges are counted only when `ce`=1.
- Z slots are updated in place during RUN, so Z is only meaningful while `out_valid`=1.

## Test plan
- LENGTH=5, input P elements e4..e0 (element 4 first): 0xFFFFFFFF_C0000000, 0x00000064_80000000, 0x0000000C_E0000000, 0x00000000_80000000, 0x00000002_40000000, with `out_ready`=1. Required: Z elements e4..e0 = 0xFFFFC000, 0x00648000, 0x000CE000, 0x00008000, 0x00024000; sat=0; `out_valid` rises 5 edges after accept.
- Rounding, LENGTH=2, e1=0xFFFFFFFF_FFFF8000, e0=0x00000000_00008000. Required: e1→0x00000000, e0→0x00000001, sat=0.
- Saturation, LENGTH=2, e1=0xFFFF7FFF_00000000, e0=0x00008000_00000000. Required: e1→0x80000000, e0→0x7FFFFFFF, sat=2'b11.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE. Required: `out_valid`, Z and sat stable and `in_ready`=0 throughout; a `in_valid` pulse during that window is not accepted; one-cycle `out_ready` returns the block to IDLE.
- `ce` low for 3 cycles mid-RUN. Required: `idx` frozen and `out_valid` delayed by exactly 3 cycles; Z matches the uninterrupted case.
- `rst_n` pulsed low at edge 2 of RUN. Required: Z=0, sat=0, `out_valid`=0 immediately (asynchronously); after release, `in_ready`=1 and the next vector converts correctly.
